// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the multicycle MIPS datapath.
// Fetches one word at the current PC over a read/waitrequest handshake,
// latches it into the instruction register and hands PC+PC_STEP back to
// the PC register with a one-cycle write strobe. All outputs are registered.
module instr_fetch_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int PC_STEP     = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      cur_pc_val,
    input  logic                   fetch_req,
    input  logic                   flush,
    output logic [ADDR_W-1:0]      mem_address,
    output logic                   mem_read,
    input  logic                   mem_waitrequest,
    input  logic [DATA_W-1:0]      mem_readdata,
    output logic [ADDR_W-1:0]      nxt_pc_val,
    output logic                   pc_ctrl,
    output logic [DATA_W-1:0]      instr,
    output logic                   instr_valid,
    output logic                   fetch_busy,
    output logic                   misaligned_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        UPDATE = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;        // PC captured at fetch start; later cur_pc_val changes are ignored
    logic              flush_pend;  // a redirect arrived while the read was still outstanding

    // The captured PC doubles as the memory address so it stays stable for the whole request.
    assign mem_address = pc_q;

    // Fetch sequencer: IDLE -> REQ (wait for memory) -> UPDATE -> IDLE, or IDLE -> ERR -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pc_q           <= '0;
            flush_pend     <= 1'b0;
            mem_read       <= 1'b0;
            nxt_pc_val     <= '0;
            pc_ctrl        <= 1'b0;
            instr          <= '0;
            instr_valid    <= 1'b0;
            fetch_busy     <= 1'b0;
            misaligned_err <= 1'b0;
            stall_cycles   <= '0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            pc_ctrl        <= 1'b0;
            instr_valid    <= 1'b0;
            misaligned_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        fetch_busy <= 1'b1;
                        if (cur_pc_val[1:0] == 2'b00) begin
                            pc_q     <= cur_pc_val;
                            mem_read <= 1'b1;
                            state    <= REQ;
                        end else begin
                            // Unaligned PC: refuse without touching memory.
                            misaligned_err <= 1'b1;
                            state          <= ERR;
                        end
                    end
                end

                REQ: begin
                    // The request cannot be withdrawn once issued, so a flush is only remembered.
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_waitrequest) begin
                        if (stall_cycles != '1) begin
                            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
                        end
                    end else begin
                        mem_read <= 1'b0;
                        state    <= UPDATE;
                        if (!(flush_pend || flush)) begin
                            instr       <= mem_readdata;
                            instr_valid <= 1'b1;
                            pc_ctrl     <= 1'b1;
                            nxt_pc_val  <= pc_q + ADDR_W'(PC_STEP);
                        end
                    end
                end

                UPDATE: begin
                    flush_pend <= 1'b0;
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end

                ERR: begin
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
